// File: rtl/arch_defs_pkg.sv
// rtl/arch_defs_pkg.sv - shared widths, memory map, opcodes and FSM states for the SAP-2 computer
package arch_defs_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 16;

   localparam int ROM_DEPTH = 4096;
   localparam int ROM_AW    = 12;
   localparam int RAM_DEPTH = 256;
   localparam int RAM_AW    = 8;

   localparam logic [ADDR_WIDTH-1:0] ROM_LAST = 16'h0FFF;
   localparam logic [ADDR_WIDTH-1:0] RAM_BASE = 16'h1000;
   localparam logic [ADDR_WIDTH-1:0] RAM_LAST = 16'h10FF;

   typedef enum logic [7:0] {
      OP_NOP   = 8'h00,
      OP_HLT   = 8'h01,
      OP_MVI_A = 8'h10,
      OP_MVI_B = 8'h11,
      OP_INR_A = 8'h20,
      OP_INR_B = 8'h21,
      OP_DCR_A = 8'h22,
      OP_DCR_B = 8'h23,
      OP_MOV_AB = 8'h30,
      OP_MOV_BA = 8'h31,
      OP_ADD_B = 8'h40,
      OP_OUT   = 8'h50,
      OP_JMP   = 8'h60,
      OP_LDA   = 8'h70,
      OP_STA   = 8'h71
   } opcode_t;

   typedef enum logic [2:0] {
      S_F0, S_F1, S_O0, S_O1, S_M0, S_EX, S_HLT
   } state_t;

   typedef enum logic [1:0] {
      REG_NONE, REG_ROM, REG_RAM
   } region_t;

   function automatic logic has_operand(input logic [7:0] op);
      return (op == OP_MVI_A) || (op == OP_MVI_B) || (op == OP_JMP) ||
             (op == OP_LDA) || (op == OP_STA);
   endfunction
endpackage

// File: rtl/sap2_cpu.sv
// rtl/sap2_cpu.sv - multi-cycle CPU core: FSM, PC, IR, A, B, flags and output register
module sap2_cpu
   import arch_defs_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   output logic                  instr_complete,
   output logic                  halt,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic [DATA_WIDTH-1:0] a_out,
   output logic [DATA_WIDTH-1:0] b_out,
   output logic                  flag_zero_o,
   output logic                  flag_negative_o,
   output logic                  flag_carry_o
);
   state_t state, state_nx;
   logic [ADDR_WIDTH-1:0] pc, pc_nx;
   logic [7:0] ir, opl, oph, a, b, out_q;
   logic fz, fn, fc;
   logic [7:0] a_nx, b_nx, out_nx, zn_src;
   logic z_nx, n_nx, c_nx, set_zn;
   logic [8:0] sum9;

   // Memory is synchronous-read, so each state presents the address whose data the next state consumes.
   always_comb begin
      state_nx = state;
      mem_addr = pc;
      case (state)
         S_F0: state_nx = S_F1;
         S_F1: begin
            mem_addr = pc + 16'd1;
            state_nx = has_operand(mem_rdata) ? S_O0 : S_EX;
         end
         S_O0: begin
            mem_addr = pc + 16'd1;
            state_nx = (ir == OP_MVI_A || ir == OP_MVI_B) ? S_EX : S_O1;
         end
         S_O1: state_nx = (ir == OP_LDA) ? S_M0 : S_EX;
         S_M0: begin
            mem_addr = {oph, opl};
            state_nx = S_EX;
         end
         S_EX: begin
            mem_addr = {oph, opl};
            state_nx = (ir == OP_HLT) ? S_HLT : S_F0;
         end
         S_HLT: state_nx = S_HLT;
         default: state_nx = S_F0;
      endcase
   end

   assign sum9 = {1'b0, a} + {1'b0, b};

   always_comb begin
      a_nx = a;
      b_nx = b;
      out_nx = out_q;
      pc_nx = pc;
      z_nx = fz;
      n_nx = fn;
      c_nx = fc;
      zn_src = 8'h00;
      set_zn = 1'b0;
      case (ir)
         OP_MVI_A:  begin a_nx = opl;        zn_src = opl;        set_zn = 1'b1; end
         OP_MVI_B:  begin b_nx = opl;        zn_src = opl;        set_zn = 1'b1; end
         OP_INR_A:  begin a_nx = a + 8'd1;   zn_src = a + 8'd1;   set_zn = 1'b1; end
         OP_INR_B:  begin b_nx = b + 8'd1;   zn_src = b + 8'd1;   set_zn = 1'b1; end
         OP_DCR_A:  begin a_nx = a - 8'd1;   zn_src = a - 8'd1;   set_zn = 1'b1; end
         OP_DCR_B:  begin b_nx = b - 8'd1;   zn_src = b - 8'd1;   set_zn = 1'b1; end
         OP_MOV_AB: begin a_nx = b;          zn_src = b;          set_zn = 1'b1; end
         OP_MOV_BA: begin b_nx = a;          zn_src = a;          set_zn = 1'b1; end
         OP_ADD_B:  begin
            a_nx = sum9[7:0];
            c_nx = sum9[8];
            zn_src = sum9[7:0];
            set_zn = 1'b1;
         end
         OP_OUT:    out_nx = a;
         OP_JMP:    pc_nx = {oph, opl};
         OP_LDA:    begin a_nx = mem_rdata;  zn_src = mem_rdata;  set_zn = 1'b1; end
         default:   ;
      endcase
      if (set_zn) begin
         z_nx = (zn_src == 8'h00);
         n_nx = zn_src[7];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_F0;
         pc <= '0;
         ir <= '0;
         opl <= '0;
         oph <= '0;
         a <= '0;
         b <= '0;
         out_q <= '0;
         fz <= 1'b0;
         fn <= 1'b0;
         fc <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            S_F1: begin
               ir <= mem_rdata;
               pc <= pc + 16'd1;
            end
            S_O0: begin
               opl <= mem_rdata;
               pc <= pc + 16'd1;
            end
            S_O1: begin
               oph <= mem_rdata;
               pc <= pc + 16'd1;
            end
            S_EX: begin
               pc <= pc_nx;
               a <= a_nx;
               b <= b_nx;
               out_q <= out_nx;
               fz <= z_nx;
               fn <= n_nx;
               fc <= c_nx;
            end
            default: ;
         endcase
      end
   end

   assign mem_we = (state == S_EX) && (ir == OP_STA);
   assign mem_wdata = a;
   assign instr_complete = (state == S_EX);
   assign halt = (state == S_HLT);
   assign out_port = out_q;
   assign a_out = a;
   assign b_out = b;
   assign flag_zero_o = fz;
   assign flag_negative_o = fn;
   assign flag_carry_o = fc;
endmodule

// File: rtl/sap2_ram.sv
// rtl/sap2_ram.sv - synchronous-read, synchronous-write data RAM
module sap2_ram
   import arch_defs_pkg::*;
(
   input  logic              clk,
   input  logic [RAM_AW-1:0] addr,
   input  logic              we,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata
);
   logic [7:0] mem [0:RAM_DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

   task init_sim_ram;
      for (int i = 0; i < RAM_DEPTH; i++) mem[i] <= 8'h00;
   endtask
endmodule

// File: rtl/sap2_rom.sv
// rtl/sap2_rom.sv - synchronous-read program ROM, loaded from simulation only
module sap2_rom
   import arch_defs_pkg::*;
(
   input  logic              clk,
   input  logic [ROM_AW-1:0] addr,
   output logic [7:0]        rdata
);
   logic [7:0] mem [0:ROM_DEPTH-1];

   always_ff @(posedge clk) begin
      rdata <= mem[addr];
   end

   task init_sim_rom;
      for (int i = 0; i < ROM_DEPTH; i++) mem[i] = 8'h00;
   endtask

   // Discards the current image, leaving the ROM zero-filled.
   task dump;
      for (int i = 0; i < ROM_DEPTH; i++) mem[i] = 8'h00;
   endtask
endmodule

// File: rtl/sap2_computer.sv
// rtl/sap2_computer.sv - SAP-2 top level: CPU, ROM, RAM, address decode and read-data mux
module sap2_computer
   import arch_defs_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   output logic [DATA_WIDTH-1:0] output_port_1,
   input  logic                  uart_rx,
   output logic                  uart_tx
);
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0] cpu_wdata, cpu_rdata, rom_rdata, ram_rdata;
   logic cpu_we, cpu_instr_complete, cpu_halt;
   logic rom_hit, ram_hit;
   region_t sel_q;
   logic unused_uart_rx;

   assign unused_uart_rx = uart_rx;
   assign uart_tx = 1'b1;

   assign rom_hit = (cpu_addr <= ROM_LAST);
   assign ram_hit = (cpu_addr >= RAM_BASE) && (cpu_addr <= RAM_LAST);

   // Read data arrives a cycle after the address, so the region select is delayed to match.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sel_q <= REG_NONE;
      else if (rom_hit) sel_q <= REG_ROM;
      else if (ram_hit) sel_q <= REG_RAM;
      else sel_q <= REG_NONE;
   end

   always_comb begin
      cpu_rdata = 8'h00;
      case (sel_q)
         REG_ROM: cpu_rdata = rom_rdata;
         REG_RAM: cpu_rdata = ram_rdata;
         default: cpu_rdata = 8'h00;
      endcase
   end

   sap2_cpu u_cpu (
      .clk             (clk),
      .reset           (reset),
      .mem_rdata       (cpu_rdata),
      .mem_addr        (cpu_addr),
      .mem_wdata       (cpu_wdata),
      .mem_we          (cpu_we),
      .instr_complete  (cpu_instr_complete),
      .halt            (cpu_halt),
      .out_port        (output_port_1),
      .a_out           (),
      .b_out           (),
      .flag_zero_o     (),
      .flag_negative_o (),
      .flag_carry_o    ()
   );

   sap2_rom u_rom (
      .clk   (clk),
      .addr  (cpu_addr[ROM_AW-1:0]),
      .rdata (rom_rdata)
   );

   sap2_ram u_ram (
      .clk   (clk),
      .addr  (cpu_addr[RAM_AW-1:0]),
      .we    (cpu_we && ram_hit),
      .wdata (cpu_wdata),
      .rdata (ram_rdata)
   );
endmodule

// File: tb/tb_sap2_computer.sv
// tb/tb_sap2_computer.sv - directed and randomized programs checked against an instruction-level model
module tb_sap2_computer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic uart_rx = 1'b1;
   logic [7:0] output_port_1;
   logic uart_tx;

   int n_tests = 0;
   int n_fail = 0;

   logic [7:0] rom_img [0:4095];
   logic [7:0] m_ram [0:255];
   logic [15:0] m_pc;
   logic [7:0] m_a, m_b, m_out;
   logic m_z, m_n, m_c, m_halt;
   logic [7:0] prog [$];

   sap2_computer dut (
      .clk           (clk),
      .reset         (reset),
      .output_port_1 (output_port_1),
      .uart_rx       (uart_rx),
      .uart_tx       (uart_tx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] m_read(input logic [15:0] ad);
      if (ad <= 16'h0FFF) return rom_img[ad[11:0]];
      if (ad <= 16'h10FF) return m_ram[ad[7:0]];
      return 8'h00;
   endfunction

   // One whole instruction at ISA level; returns its length in cycles.
   task automatic m_step(output int len);
      logic [7:0] op, imm;
      logic [15:0] tgt;
      int sum;
      op = m_read(m_pc);
      imm = m_read(m_pc + 16'd1);
      tgt = {m_read(m_pc + 16'd2), imm};
      len = 3;
      case (op)
         8'h01: m_halt = 1'b1;
         8'h10: begin m_a = imm; m_z = (m_a == 0); m_n = m_a[7]; len = 4; end
         8'h11: begin m_b = imm; m_z = (m_b == 0); m_n = m_b[7]; len = 4; end
         8'h20: begin m_a = m_a + 8'd1; m_z = (m_a == 0); m_n = m_a[7]; end
         8'h21: begin m_b = m_b + 8'd1; m_z = (m_b == 0); m_n = m_b[7]; end
         8'h22: begin m_a = m_a - 8'd1; m_z = (m_a == 0); m_n = m_a[7]; end
         8'h23: begin m_b = m_b - 8'd1; m_z = (m_b == 0); m_n = m_b[7]; end
         8'h30: begin m_a = m_b; m_z = (m_a == 0); m_n = m_a[7]; end
         8'h31: begin m_b = m_a; m_z = (m_b == 0); m_n = m_b[7]; end
         8'h40: begin
            sum = int'(m_a) + int'(m_b);
            m_c = (sum > 255);
            m_a = 8'(sum % 256);
            m_z = (m_a == 0);
            m_n = m_a[7];
         end
         8'h50: m_out = m_a;
         8'h60: len = 5;
         8'h70: begin m_a = m_read(tgt); m_z = (m_a == 0); m_n = m_a[7]; len = 6; end
         8'h71: begin
            if (tgt >= 16'h1000 && tgt <= 16'h10FF) m_ram[tgt[7:0]] = m_a;
            len = 5;
         end
         default: ;
      endcase
      if (op == 8'h60) m_pc = tgt;
      else if (len == 3) m_pc = m_pc + 16'd1;
      else if (len == 4) m_pc = m_pc + 16'd2;
      else m_pc = m_pc + 16'd3;
   endtask

   task automatic load_prog(input logic [7:0] q[$]);
      dut.u_rom.init_sim_rom();
      dut.u_ram.init_sim_ram();
      for (int i = 0; i < 4096; i++) rom_img[i] = 8'h00;
      for (int i = 0; i < 256; i++) m_ram[i] = 8'h00;
      for (int i = 0; i < q.size(); i++) begin
         rom_img[i] = q[i];
         dut.u_rom.mem[i] = q[i];
      end
   endtask

   task automatic do_reset(input string name);
      reset = 1'b1;
      uart_rx = 1'($urandom);
      @(posedge clk);
      #1;
      check({name, ":rst_a"}, dut.u_cpu.a_out, 8'h00);
      check({name, ":rst_b"}, dut.u_cpu.b_out, 8'h00);
      check({name, ":rst_flags"}, {dut.u_cpu.flag_zero_o, dut.u_cpu.flag_negative_o, dut.u_cpu.flag_carry_o}, 3'b000);
      check({name, ":rst_ctl"}, {dut.cpu_instr_complete, dut.cpu_halt, output_port_1}, 10'h000);
      @(negedge clk);
      reset = 1'b0;
      m_pc = 16'h0000;
      m_a = 8'h00; m_b = 8'h00; m_out = 8'h00;
      m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_halt = 1'b0;
   endtask

   task automatic run_instr(input string name, output logic ok);
      int cyc, len;
      m_step(len);
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!dut.cpu_instr_complete && cyc < 40);
      check({name, ":cycles"}, cyc, len - 1);
      ok = dut.cpu_instr_complete;
      if (ok) begin
         @(posedge clk);
         #1;
         check({name, ":a"}, dut.u_cpu.a_out, m_a);
         check({name, ":b"}, dut.u_cpu.b_out, m_b);
         check({name, ":znc"}, {dut.u_cpu.flag_zero_o, dut.u_cpu.flag_negative_o, dut.u_cpu.flag_carry_o}, {m_z, m_n, m_c});
         check({name, ":port"}, output_port_1, m_out);
         check({name, ":uart_tx"}, uart_tx, 1'b1);
      end
   endtask

   task automatic run_prog(input string name);
      logic ok;
      ok = 1'b1;
      for (int k = 0; k < 100 && ok && !m_halt; k++) run_instr(name, ok);
      check({name, ":halt"}, dut.cpu_halt, m_halt);
      if (m_halt) begin
         repeat (5) @(posedge clk);
         #1;
         check({name, ":stays_halted"}, {dut.cpu_halt, dut.cpu_instr_complete}, 2'b10);
      end
   endtask

   function automatic logic [15:0] pick_addr();
      case ($urandom_range(0, 5))
         4: return 16'h2345;
         5: return 16'h0002;
         default: return 16'h1000 + 16'($urandom_range(0, 7));
      endcase
   endfunction

   task automatic gen_random(output logic [7:0] q[$]);
      logic [7:0] one_byte [12] = '{8'h00, 8'h20, 8'h21, 8'h22, 8'h23, 8'h30,
                                    8'h31, 8'h40, 8'h50, 8'h02, 8'h7F, 8'hFE};
      logic [7:0] imms [5] = '{8'h00, 8'h7F, 8'h80, 8'hFF, 8'h01};
      logic [15:0] ad;
      q = {};
      for (int k = 0; k < 14; k++) begin
         case ($urandom_range(0, 4))
            0, 1: q.push_back(one_byte[$urandom_range(0, 11)]);
            2: begin
               q.push_back($urandom_range(0, 1) ? 8'h10 : 8'h11);
               q.push_back($urandom_range(0, 1) ? imms[$urandom_range(0, 4)] : 8'($urandom));
            end
            3: begin
               ad = pick_addr();
               q.push_back($urandom_range(0, 1) ? 8'h70 : 8'h71);
               q.push_back(ad[7:0]);
               q.push_back(ad[15:8]);
            end
            default: begin
               // Jump over a planted HLT so a missed jump is visible.
               ad = 16'(q.size() + 4);
               q.push_back(8'h60);
               q.push_back(ad[7:0]);
               q.push_back(ad[15:8]);
               q.push_back(8'h01);
            end
         endcase
      end
      q.push_back(8'h01);
   endtask

   initial begin
      logic ok;

      prog = '{8'h21, 8'h21, 8'h01};
      load_prog(prog);
      do_reset("inr_b");
      run_prog("inr_b");
      check("inr_b:final_b", dut.u_cpu.b_out, 8'h02);

      prog = '{8'h11, 8'hFF, 8'h21, 8'h01};
      load_prog(prog);
      do_reset("wrap");
      run_prog("wrap");
      check("wrap:final_znc", {dut.u_cpu.flag_zero_o, dut.u_cpu.flag_negative_o, dut.u_cpu.flag_carry_o}, 3'b100);

      prog = '{8'h10, 8'h80, 8'h11, 8'h90, 8'h40, 8'h50, 8'h01};
      load_prog(prog);
      do_reset("add");
      run_prog("add");
      check("add:port", output_port_1, 8'h10);
      check("add:carry", dut.u_cpu.flag_carry_o, 1'b1);

      prog = '{8'h10, 8'h5A, 8'h71, 8'h00, 8'h10, 8'h10, 8'h00, 8'h70, 8'h00, 8'h10, 8'h01};
      load_prog(prog);
      do_reset("sta_lda");
      run_prog("sta_lda");
      check("sta_lda:ram0", dut.u_ram.mem[0], 8'h5A);
      check("sta_lda:final_a", dut.u_cpu.a_out, 8'h5A);

      prog = '{8'h60, 8'h05, 8'h00, 8'h21, 8'h01, 8'h21, 8'h01};
      load_prog(prog);
      do_reset("jmp");
      run_prog("jmp");
      check("jmp:final_b", dut.u_cpu.b_out, 8'h01);

      prog = '{8'h10, 8'h77, 8'h11, 8'h33, 8'h01};
      load_prog(prog);
      do_reset("midrst");
      run_instr("midrst", ok);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("midrst:a", dut.u_cpu.a_out, 8'h00);
      check("midrst:b", dut.u_cpu.b_out, 8'h00);
      check("midrst:pc", dut.u_cpu.pc, 16'h0000);
      do_reset("midrst2");
      run_prog("midrst2");

      for (int p = 0; p < 8; p++) begin
         gen_random(prog);
         load_prog(prog);
         do_reset($sformatf("rnd%0d", p));
         run_prog($sformatf("rnd%0d", p));
         for (int i = 0; i < 8; i++)
            check($sformatf("rnd%0d:ram%0d", p, i), dut.u_ram.mem[i], m_ram[i]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
